launch_sequencer: RTL and testbench

Central bird-turn controller for the GAME scene.
- Selects the active bird (0, 1, 2, then NONE).
- Steps the active bird through load, aim, shoot and fly phases, paced by the per-frame tick.
- Owns the aim vector driven by the W/A/S/D keys and the space-bar fire edge.
- Feeds macro_state, bird_state, cnt and the launch vector to the bird, pig and collision blocks.

---
 rtl/angry_pkg.sv | 20 ++
 rtl/launch_sequencer_if.sv | 35 +++
 rtl/aim_ctrl.sv | 53 +++++
 rtl/launch_sequencer.sv | 138 +++++++++++++
 tb/tb_launch_sequencer.sv | 208 ++++++++++++++++++++
 5 files changed

// File: rtl/angry_pkg.sv
// Shared encodings and widths for the bird-turn launch sequencer.
package angry_pkg;

    localparam int AIM_W = 17;

    typedef enum logic [1:0] {
        WAIT_FOR_LOAD = 2'd0,
        LOADING_ANIM  = 2'd1,
        WAIT_FOR_SHOT = 2'd2,
        FLYING        = 2'd3
    } bird_state_t;

    typedef enum logic [2:0] {
        BIRD_0 = 3'd0,
        BIRD_1 = 3'd1,
        BIRD_2 = 3'd2,
        NONE   = 3'd7
    } macro_t;

endpackage

// File: rtl/launch_sequencer_if.sv
// Control inputs and per-bird outputs exchanged between the game scene and the sequencer.
interface launch_sequencer_if;
    import angry_pkg::*;

    logic                    frame_tick;
    logic                    en;
    logic                    shoot;
    logic                    key_w;
    logic                    key_a;
    logic                    key_s;
    logic                    key_d;
    logic                    fly_done;
    logic [2:0]              macro_state;
    logic [1:0]              bird_state;
    logic [9:0]              cnt;
    logic signed [AIM_W-1:0] delta_x;
    logic signed [AIM_W-1:0] delta_y;
    logic                    launch;
    logic signed [AIM_W-1:0] launch_dx;
    logic signed [AIM_W-1:0] launch_dy;
    logic                    birds_done;

    modport master (
        output frame_tick, en, shoot, key_w, key_a, key_s, key_d, fly_done,
        input  macro_state, bird_state, cnt, delta_x, delta_y,
               launch, launch_dx, launch_dy, birds_done
    );

    modport slave (
        input  frame_tick, en, shoot, key_w, key_a, key_s, key_d, fly_done,
        output macro_state, bird_state, cnt, delta_x, delta_y,
               launch, launch_dx, launch_dy, birds_done
    );

endinterface

// File: rtl/aim_ctrl.sv
// Two-axis saturating up/down aim counter with synchronous clear and update enable.
module aim_ctrl
    import angry_pkg::*;
#(
    parameter int AIM_MAX = 63
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clr,
    input  logic                    upd,
    input  logic                    inc_x,
    input  logic                    dec_x,
    input  logic                    inc_y,
    input  logic                    dec_y,
    output logic signed [AIM_W-1:0] x,
    output logic signed [AIM_W-1:0] y
);

    // Opposing keys cancel; the clamp is applied to the stepped value.
    function automatic logic signed [AIM_W-1:0] step(
        input logic signed [AIM_W-1:0] cur,
        input logic                    inc,
        input logic                    dec
    );
        logic signed [AIM_W-1:0] nxt;
        logic signed [AIM_W-1:0] lim;
        lim = AIM_W'(AIM_MAX);
        nxt = cur;
        if (inc && !dec)
            nxt = cur + AIM_W'(1);
        else if (dec && !inc)
            nxt = cur - AIM_W'(1);
        if (nxt > lim)
            nxt = lim;
        else if (nxt < -lim)
            nxt = -lim;
        return nxt;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            x <= '0;
            y <= '0;
        end else if (clr) begin
            x <= '0;
            y <= '0;
        end else if (upd) begin
            x <= step(x, inc_x, dec_x);
            y <= step(y, inc_y, dec_y);
        end
    end

endmodule

// File: rtl/launch_sequencer.sv
// Bird-turn controller: selects the active bird and walks it through load, aim, shoot and fly.
//   state         | meaning
//   WAIT_FOR_LOAD | idle before the next bird's load animation
//   LOADING_ANIM  | counting LOAD_FRAMES ticks of load animation
//   WAIT_FOR_SHOT | aim live from W/A/S/D, waiting for space-bar edge
//   FLYING        | bird in flight until FLY_FRAMES or fly_done
module launch_sequencer
    import angry_pkg::*;
#(
    parameter int LOAD_FRAMES = 32,
    parameter int FLY_FRAMES  = 480,
    parameter int AIM_MAX     = 63,
    parameter int NUM_BIRDS   = 3
) (
    input  logic          clk,
    input  logic          rst,
    launch_sequencer_if.slave bus
);

    bird_state_t             state_q, state_d;
    macro_t                  macro_q, macro_d;
    logic [9:0]              cnt_q, cnt_d;
    logic                    shoot_prev_q, shoot_prev_d;
    logic                    launch_q, launch_d;
    logic                    birds_done_q, birds_done_d;
    logic signed [AIM_W-1:0] ldx_q, ldx_d, ldy_q, ldy_d;
    logic signed [AIM_W-1:0] aim_x, aim_y;
    logic                    adv, fire, aim_clr, aim_upd;

    assign adv  = bus.frame_tick && bus.en;
    assign fire = bus.shoot && !shoot_prev_q;

    aim_ctrl #(.AIM_MAX(AIM_MAX)) u_aim (
        .clk   (clk),
        .rst   (rst),
        .clr   (aim_clr),
        .upd   (aim_upd),
        .inc_x (bus.key_d),
        .dec_x (bus.key_a),
        .inc_y (bus.key_s),
        .dec_y (bus.key_w),
        .x     (aim_x),
        .y     (aim_y)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= WAIT_FOR_LOAD;
            macro_q      <= BIRD_0;
            cnt_q        <= '0;
            shoot_prev_q <= 1'b0;
            launch_q     <= 1'b0;
            birds_done_q <= 1'b0;
            ldx_q        <= '0;
            ldy_q        <= '0;
        end else begin
            state_q      <= state_d;
            macro_q      <= macro_d;
            cnt_q        <= cnt_d;
            shoot_prev_q <= shoot_prev_d;
            launch_q     <= launch_d;
            birds_done_q <= birds_done_d;
            ldx_q        <= ldx_d;
            ldy_q        <= ldy_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        macro_d      = macro_q;
        cnt_d        = cnt_q;
        shoot_prev_d = shoot_prev_q;
        ldx_d        = ldx_q;
        ldy_d        = ldy_q;
        launch_d     = 1'b0;
        aim_clr      = 1'b0;
        aim_upd      = 1'b0;
        if (adv) begin
            shoot_prev_d = bus.shoot;
            if (macro_q == NONE) begin
                state_d = WAIT_FOR_LOAD;
                cnt_d   = '0;
            end else begin
                case (state_q)
                    WAIT_FOR_LOAD: begin
                        state_d = LOADING_ANIM;
                        cnt_d   = '0;
                        aim_clr = 1'b1;
                    end
                    LOADING_ANIM: begin
                        if (cnt_q == 10'(LOAD_FRAMES - 1)) begin
                            state_d = WAIT_FOR_SHOT;
                            cnt_d   = '0;
                        end else begin
                            cnt_d = cnt_q + 10'd1;
                        end
                    end
                    WAIT_FOR_SHOT: begin
                        cnt_d   = '0;
                        aim_upd = 1'b1;
                        // Latch uses the aim as it stood before this tick's key step.
                        if (fire) begin
                            state_d  = FLYING;
                            launch_d = 1'b1;
                            ldx_d    = aim_x;
                            ldy_d    = aim_y;
                        end
                    end
                    FLYING: begin
                        if (cnt_q == 10'(FLY_FRAMES - 1) || bus.fly_done) begin
                            state_d = WAIT_FOR_LOAD;
                            cnt_d   = '0;
                            if (int'(macro_q) == NUM_BIRDS - 1)
                                macro_d = NONE;
                            else
                                macro_d = macro_t'(macro_q + 3'd1);
                        end else begin
                            cnt_d = cnt_q + 10'd1;
                        end
                    end
                    default: state_d = WAIT_FOR_LOAD;
                endcase
            end
        end
        birds_done_d = (macro_d == NONE);
    end

    assign bus.macro_state = macro_q;
    assign bus.bird_state  = state_q;
    assign bus.cnt         = cnt_q;
    assign bus.delta_x     = aim_x;
    assign bus.delta_y     = aim_y;
    assign bus.launch      = launch_q;
    assign bus.launch_dx   = ldx_q;
    assign bus.launch_dy   = ldy_q;
    assign bus.birds_done  = birds_done_q;

endmodule

// File: tb/tb_launch_sequencer.sv
// Directed self-checking bench for launch_sequencer: turn sequencing, aim saturation, fire edge, reset.
module tb_launch_sequencer;

    logic clk;
    logic rst;
    int   tests;
    int   fails;

    launch_sequencer_if bus ();

    launch_sequencer dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, $signed(obs), $signed(exp));
        end
    endtask

    task automatic tick();
        @(negedge clk);
        bus.frame_tick = 1'b1;
        @(negedge clk);
        bus.frame_tick = 1'b0;
    endtask

    task automatic ticks(input int n);
        repeat (n) tick();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    function automatic logic [31:0] sx(input logic signed [16:0] v);
        return 32'(v);
    endfunction

    initial begin
        tests = 0;
        fails = 0;
        rst = 1'b0;
        bus.frame_tick = 1'b0;
        bus.en = 1'b1;
        bus.shoot = 1'b0;
        bus.key_w = 1'b0;
        bus.key_a = 1'b0;
        bus.key_s = 1'b0;
        bus.key_d = 1'b0;
        bus.fly_done = 1'b0;
        do_reset();
        check("rst_macro", 32'(bus.macro_state), 32'd0);
        check("rst_state", 32'(bus.bird_state), 32'd0);
        check("rst_cnt", 32'(bus.cnt), 32'd0);
        check("rst_dx", sx(bus.delta_x), 32'd0);
        check("rst_launch", 32'(bus.launch), 32'd0);
        check("rst_done", 32'(bus.birds_done), 32'd0);

        // Frozen while disabled; shoot held from before aiming.
        bus.shoot = 1'b1;
        bus.en = 1'b0;
        ticks(3);
        check("en0_state", 32'(bus.bird_state), 32'd0);
        bus.en = 1'b1;

        tick();
        check("load_state", 32'(bus.bird_state), 32'd1);
        check("load_cnt", 32'(bus.cnt), 32'd0);
        ticks(31);
        check("load_cnt31", 32'(bus.cnt), 32'd31);
        check("load_state31", 32'(bus.bird_state), 32'd1);
        tick();
        check("wfs_state", 32'(bus.bird_state), 32'd2);
        check("wfs_cnt", 32'(bus.cnt), 32'd0);

        bus.key_d = 1'b1;
        ticks(10);
        check("aim_x10", sx(bus.delta_x), 32'd10);
        ticks(60);
        check("aim_x_sat", sx(bus.delta_x), 32'd63);
        check("held_shoot_nofire", 32'(bus.bird_state), 32'd2);
        bus.key_a = 1'b1;
        ticks(5);
        check("aim_x_ad", sx(bus.delta_x), 32'd63);
        bus.key_d = 1'b0;
        bus.key_a = 1'b0;
        bus.key_w = 1'b1;
        ticks(100);
        check("aim_y_sat", sx(bus.delta_y), -32'sd63);
        bus.key_w = 1'b0;
        bus.key_a = 1'b1;
        ticks(3);
        check("aim_x60", sx(bus.delta_x), 32'd60);
        bus.key_a = 1'b0;
        bus.shoot = 1'b0;
        tick();
        check("release_state", 32'(bus.bird_state), 32'd2);

        // Fire with S pressed on the same tick: latch takes pre-step aim.
        bus.shoot = 1'b1;
        bus.key_s = 1'b1;
        tick();
        bus.key_s = 1'b0;
        check("fire_launch", 32'(bus.launch), 32'd1);
        check("fire_ldx", sx(bus.launch_dx), 32'd60);
        check("fire_ldy", sx(bus.launch_dy), -32'sd63);
        check("fire_state", 32'(bus.bird_state), 32'd3);
        check("fire_cnt", 32'(bus.cnt), 32'd0);
        @(negedge clk);
        check("launch_pulse", 32'(bus.launch), 32'd0);
        bus.shoot = 1'b0;

        ticks(479);
        check("fly_cnt479", 32'(bus.cnt), 32'd479);
        check("fly_state479", 32'(bus.bird_state), 32'd3);
        tick();
        check("fly_end_state", 32'(bus.bird_state), 32'd0);
        check("fly_end_macro", 32'(bus.macro_state), 32'd1);

        // Bird 1: early end via fly_done at cnt 10, with an en=0 pause.
        tick();
        check("b1_clear_dx", sx(bus.delta_x), 32'd0);
        check("b1_clear_dy", sx(bus.delta_y), 32'd0);
        ticks(32);
        bus.shoot = 1'b1;
        tick();
        check("b1_launch", 32'(bus.launch), 32'd1);
        check("b1_ldx", sx(bus.launch_dx), 32'd0);
        bus.shoot = 1'b0;
        ticks(10);
        bus.en = 1'b0;
        ticks(5);
        check("en0_cnt", 32'(bus.cnt), 32'd10);
        check("en0_fly", 32'(bus.bird_state), 32'd3);
        bus.en = 1'b1;
        bus.fly_done = 1'b1;
        tick();
        bus.fly_done = 1'b0;
        check("b1_done_state", 32'(bus.bird_state), 32'd0);
        check("b1_done_macro", 32'(bus.macro_state), 32'd2);
        check("b1_done_cnt", 32'(bus.cnt), 32'd0);

        // Bird 2: timeout and fly_done coincide -> single advance to NONE.
        tick();
        ticks(32);
        bus.shoot = 1'b1;
        tick();
        bus.shoot = 1'b0;
        ticks(479);
        bus.fly_done = 1'b1;
        tick();
        bus.fly_done = 1'b0;
        check("none_macro", 32'(bus.macro_state), 32'd7);
        check("none_done", 32'(bus.birds_done), 32'd1);
        check("none_state", 32'(bus.bird_state), 32'd0);

        bus.shoot = 1'b1;
        bus.key_d = 1'b1;
        tick();
        check("none_nolaunch", 32'(bus.launch), 32'd0);
        bus.shoot = 1'b0;
        ticks(5);
        bus.key_d = 1'b0;
        check("none_macro2", 32'(bus.macro_state), 32'd7);
        check("none_state2", 32'(bus.bird_state), 32'd0);
        check("none_cnt2", 32'(bus.cnt), 32'd0);
        check("none_dx", sx(bus.delta_x), 32'd0);

        do_reset();
        check("rst2_macro", 32'(bus.macro_state), 32'd0);
        check("rst2_done", 32'(bus.birds_done), 32'd0);

        // Reset in mid-flight at cnt 200.
        tick();
        ticks(32);
        bus.key_d = 1'b1;
        ticks(5);
        bus.key_d = 1'b0;
        check("mid_dx", sx(bus.delta_x), 32'd5);
        bus.shoot = 1'b1;
        tick();
        bus.shoot = 1'b0;
        check("mid_ldx", sx(bus.launch_dx), 32'd5);
        ticks(200);
        check("mid_cnt", 32'(bus.cnt), 32'd200);
        do_reset();
        check("midrst_state", 32'(bus.bird_state), 32'd0);
        check("midrst_cnt", 32'(bus.cnt), 32'd0);
        check("midrst_dx", sx(bus.delta_x), 32'd0);
        check("midrst_ldx", sx(bus.launch_dx), 32'd0);
        check("midrst_macro", 32'(bus.macro_state), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
